// File: rtl/piso_tx.sv
// Parallel-in serial-out transmitter: accepts a WIDTH-bit word and emits it MSB first with frame markers.
// Optional even-parity trailer bit is enabled by defining PISO_TX_PARITY_EN.
module piso_tx #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clear,
  input  logic [WIDTH-1:0] din,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             dout,
  output logic             dout_valid,
  output logic             frame_start,
  output logic             frame_done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

`ifdef PISO_TX_PARITY_EN
  typedef enum logic [1:0] {IDLE, SHIFT, PARITY} state_t;
`else
  typedef enum logic [0:0] {IDLE, SHIFT} state_t;
`endif

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt;
  logic             dout_nxt, valid_nxt, start_nxt, done_nxt;
  logic             last_bit, accept;
`ifdef PISO_TX_PARITY_EN
  logic             par, par_nxt;
`endif

  assign last_bit = (state == SHIFT) && (cnt == LAST);

`ifdef PISO_TX_PARITY_EN
  assign load_ready = (state == IDLE) || (state == PARITY);
`else
  assign load_ready = (state == IDLE) || last_bit;
`endif

  assign accept = load_valid && load_ready;

  // Output values are computed for the next cycle so every serial output leaves a flop.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    sreg_nxt  = sreg;
    dout_nxt  = 1'b0;
    valid_nxt = 1'b0;
    start_nxt = 1'b0;
    done_nxt  = 1'b0;
`ifdef PISO_TX_PARITY_EN
    par_nxt   = par;
`endif
    if (accept) begin
      state_nxt = SHIFT;
      cnt_nxt   = '0;
      sreg_nxt  = din;
      dout_nxt  = din[WIDTH-1];
      valid_nxt = 1'b1;
      start_nxt = 1'b1;
`ifdef PISO_TX_PARITY_EN
      par_nxt   = ^din;
`endif
    end else begin
      case (state)
        SHIFT: begin
          if (last_bit) begin
            cnt_nxt = '0;
`ifdef PISO_TX_PARITY_EN
            state_nxt = PARITY;
            dout_nxt  = par;
            valid_nxt = 1'b1;
            done_nxt  = 1'b1;
`else
            state_nxt = IDLE;
`endif
          end else begin
            // Rotating keeps every register bit in use; only the MSB side is ever emitted.
            cnt_nxt   = cnt + CNT_W'(1);
            sreg_nxt  = {sreg[WIDTH-2:0], sreg[WIDTH-1]};
            dout_nxt  = sreg[WIDTH-2];
            valid_nxt = 1'b1;
`ifndef PISO_TX_PARITY_EN
            done_nxt  = (cnt_nxt == LAST);
`endif
          end
        end
`ifdef PISO_TX_PARITY_EN
        PARITY:  state_nxt = IDLE;
`endif
        IDLE:    state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge clear) begin
    if (!clear) begin
      state       <= IDLE;
      cnt         <= '0;
      sreg        <= '0;
      dout        <= 1'b0;
      dout_valid  <= 1'b0;
      frame_start <= 1'b0;
      frame_done  <= 1'b0;
`ifdef PISO_TX_PARITY_EN
      par         <= 1'b0;
`endif
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      sreg        <= sreg_nxt;
      dout        <= dout_nxt;
      dout_valid  <= valid_nxt;
      frame_start <= start_nxt;
      frame_done  <= done_nxt;
`ifdef PISO_TX_PARITY_EN
      par         <= par_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_piso_tx.sv
// Directed bench for piso_tx: WIDTH=4 vector table plus hand sequences for clear and a WIDTH=8 frame.
module tb_piso_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       clear;
  logic [3:0] din4;
  logic       lv4;
  logic       lr4, d4, v4, fs4, fd4;
  logic [7:0] din8;
  logic       lv8;
  logic       lr8, d8, v8, fs8, fd8;

  int total = 0;
  int bad   = 0;

  piso_tx #(.WIDTH(4)) dut4 (
    .clk(clk), .clear(clear), .din(din4), .load_valid(lv4), .load_ready(lr4),
    .dout(d4), .dout_valid(v4), .frame_start(fs4), .frame_done(fd4)
  );

  piso_tx #(.WIDTH(8)) dut8 (
    .clk(clk), .clear(clear), .din(din8), .load_valid(lv8), .load_ready(lr8),
    .dout(d8), .dout_valid(v8), .frame_start(fs8), .frame_done(fd8)
  );

  typedef struct {
    logic       lv;
    logic [3:0] din;
    logic       d, v, fs, fd, lr;
  } vec_t;

  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, act, exp);
    end
  endtask

  task automatic chk4(input string nm, input logic d, v, fs, fd, lr);
    chk({nm, ".dout"}, d4, d);
    chk({nm, ".valid"}, v4, v);
    chk({nm, ".start"}, fs4, fs);
    chk({nm, ".done"}, fd4, fd);
    chk({nm, ".ready"}, lr4, lr);
  endtask

  initial begin
    logic [3:0] w4;
    logic [7:0] w8;
    int         n4, n8;
    logic       b;
`ifdef PISO_TX_PARITY_EN
    n4 = 5; n8 = 9;
    // 1011 then 0110 back to back; 1111 offered mid-frame; din wiggles while not accepting
    tbl.push_back('{1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 4'b0110, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'b1001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b0101, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
`else
    n4 = 4; n8 = 8;
    tbl.push_back('{1'b1, 4'b1011, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b1, 4'b0110, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'b1001, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b1111, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0});
    tbl.push_back('{1'b0, 4'b1111, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1});
    tbl.push_back('{1'b0, 4'b0000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1});
`endif

    clear = 1'b0; lv4 = 1'b0; din4 = '0; lv8 = 1'b0; din8 = '0;
    #2;
    chk4("reset", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("reset.ready8", lr8, 1'b1);
    @(negedge clk);
    clear = 1'b1;

    foreach (tbl[i]) begin
      @(negedge clk);
      lv4  = tbl[i].lv;
      din4 = tbl[i].din;
      chk4($sformatf("vec%0d", i), tbl[i].d, tbl[i].v, tbl[i].fs, tbl[i].fd, tbl[i].lr);
    end

    // Clear in the middle of a frame: outputs drop without a clock edge, frame is dropped.
    @(negedge clk);
    lv4 = 1'b1; din4 = 4'b1011;
    @(negedge clk);
    lv4 = 1'b0; din4 = 4'b0000;
    chk4("mid.bit1", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk4("mid.bit2", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #2 clear = 1'b0;
    #1 chk4("async_clear", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    clear = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      chk4($sformatf("post_clear%0d", k), 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    end
    lv4 = 1'b1; din4 = 4'b0001;
    w4 = 4'b0001;
    for (int k = 0; k < n4; k++) begin
      @(negedge clk);
      lv4 = 1'b0;
      b = (k < 4) ? w4[3-k] : ^w4;
      chk4($sformatf("w0001_%0d", k), b, 1'b1, k == 0, k == n4 - 1, k == n4 - 1);
    end
    @(negedge clk);
    chk4("w0001_idle", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // WIDTH=8 frame accepted on the very first edge after clear releases.
    #2 clear = 1'b0;
    @(negedge clk);
    clear = 1'b1; lv8 = 1'b1; din8 = 8'hA5;
    w8 = 8'hA5;
    for (int k = 0; k < n8; k++) begin
      @(negedge clk);
      lv8 = 1'b0; din8 = 8'hFF;
      b = (k < 8) ? w8[7-k] : ^w8;
      chk($sformatf("a5_%0d.dout", k), d8, b);
      chk($sformatf("a5_%0d.valid", k), v8, 1'b1);
      chk($sformatf("a5_%0d.start", k), fs8, k == 0);
      chk($sformatf("a5_%0d.done", k), fd8, k == n8 - 1);
    end
    @(negedge clk);
    chk("a5_idle.valid", v8, 1'b0);
    chk("a5_idle.ready", lr8, 1'b1);
    chk("a5_idle.dout", d8, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/piso_tx.md
PISO_TX -- requirements
Module: piso_tx

Interface
REQ-001 Parameter WIDTH, default 4, parallel word width; legal range 2..32.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 clear  input  1  reset, asynchronous, active-low; clear=0 resets immediately regardless of clk.
REQ-004 din  input  WIDTH  parallel word to serialize; sampled only on load accept.
REQ-005 load_valid  input  1  upstream presents a word on din.
REQ-006 load_ready  output  1  block can accept a word this cycle.
REQ-007 dout  output  1  serial data bit to the downstream serial-in parallel-out register.
REQ-008 dout_valid  output  1  dout carries a frame bit this cycle.
REQ-009 frame_start  output  1  one-cycle pulse coincident with the first bit of a frame.
REQ-010 frame_done  output  1  one-cycle pulse coincident with the last bit of a frame.

Function
REQ-011 Load accept SHALL occur on a rising edge where load_valid=1 and load_ready=1; din is then captured into an internal shift register.
REQ-012 FSM states SHALL be IDLE, SHIFT and PARITY; PARITY exists only when PISO_TX_PARITY_EN is defined.
REQ-013 IDLE: load_ready=1, dout=0, dout_valid=0; accept -> SHIFT.
REQ-014 SHIFT SHALL output din bits MSB first, one per cycle, for exactly WIDTH cycles, dout_valid=1 throughout.
REQ-015 First frame bit SHALL appear on dout in the cycle immediately after the accepting edge (latency 1 clock); all outputs registered.
REQ-016 Bit counter SHALL count 0..WIDTH-1 in SHIFT and SHALL NOT wrap into a partial frame; at WIDTH-1 SHIFT exits to PARITY (if enabled) or to IDLE/next frame.
REQ-017 frame_start=1 only in the first output bit cycle; frame_done=1 only in the final output cycle of the frame (last data bit, or parity bit when enabled).
REQ-018 load_ready SHALL be 1 in IDLE and in the final output cycle of a frame, 0 in all other cycles.
REQ-019 Accept in the final output cycle SHALL start the next frame the following cycle with no gap: dout_valid stays 1, frame_start pulses.
REQ-020 load_valid while load_ready=0 SHALL be ignored; din is not captured and the current frame is unaffected; upstream holds the word.
REQ-021 Without an accept in the final cycle, the block SHALL return to IDLE with dout=0, dout_valid=0 the next cycle.
REQ-022 din changes outside accept cycles SHALL NOT affect dout.

Reset
REQ-023 clear=0 SHALL force state IDLE, bit counter 0, shift register 0, dout=0, dout_valid=0, frame_start=0, frame_done=0, load_ready=1.
REQ-024 clear asserted mid-frame SHALL discard the frame; no remaining bits are emitted after clear releases.
REQ-025 First accept possible on the first rising edge after clear returns to 1.

Configuration
REQ-026 Macro PISO_TX_PARITY_EN: when defined, one even-parity bit (XOR of the WIDTH data bits) SHALL be emitted after the LSB, frame length WIDTH+1, dout_valid=1 in the parity cycle.
REQ-027 When PISO_TX_PARITY_EN is undefined, frame length SHALL be WIDTH with no parity state or logic present.

Verification
REQ-028 Reset: clear=0 mid-run -> all outputs 0 and load_ready=1 in the same cycle, without a clk edge.
REQ-029 WIDTH=4, accept din=4'b1011 -> dout 1,0,1,1 on cycles 1-4, dout_valid=1, frame_start cycle 1, frame_done cycle 4; with PISO_TX_PARITY_EN, cycle 5 dout=1 with frame_done moved to cycle 5.
REQ-030 Back-to-back: 4'b1011 then 4'b0110 accepted in the final cycle of the first frame -> 8 contiguous valid bits 1,0,1,1,0,1,1,0, two frame_start pulses.
REQ-031 load_valid=1 with din=4'b1111 during cycle 2 of a frame -> ignored, load_ready=0, current frame bits unchanged.
REQ-032 clear=0 after 2 bits of 4'b1011 then released -> idle, dout_valid=0, no remaining bits emitted; next accept of 4'b0001 serializes 0,0,0,1.
REQ-033 WIDTH=8, accept 8'hA5 -> dout 1,0,1,0,0,1,0,1 over 8 cycles; with PISO_TX_PARITY_EN, parity bit 0.
